sram_fifo: RTL
==============

SRAM_FIFO -- requirements
Module: sram_fifo

Interface
REQ-001 Parameter WIDTH, default 32: entry data width in bits.
REQ-002 Parameter DEPTH, default 8: number of storage-array entries; it SHALL be a power of two and at least 2.
REQ-003 Port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port i_flush, input, 1 bit: synchronous discard of all contents.
REQ-006 Port i_enq_valid, input, 1 bit: the producer offers i_enq_data.
REQ-007 Port i_enq_data, input, WIDTH bits: the enqueue payload.
REQ-008 Port o_enq_ready, output, 1 bit: the block can accept an entry this cycle.
REQ-009 Port o_deq_valid, output, 1 bit: o_deq_data holds the oldest entry.
REQ-010 Port o_deq_data, output, WIDTH bits: the dequeue payload.
REQ-011 Port i_deq_ready, input, 1 bit: the consumer accepts o_deq_data.
REQ-012 Port o_count, output, $clog2(DEPTH+2)+1 bits: total entries held (array plus in-flight plus output buffer).

Function
REQ-013 Enqueue fire SHALL equal i_enq_valid & o_enq_ready; dequeue fire SHALL equal o_deq_valid & i_deq_ready.
REQ-014 Storage SHALL be the array DEPTH x WIDTH, with 1-cycle registered read, where a read and a write to the same address in the same cycle returns the old value.
REQ-015 Write pointer and read pointer SHALL each be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0; a separate arr_count (0..DEPTH) SHALL track committed array entries.
REQ-016 o_enq_ready SHALL equal (arr_count < DEPTH) & ~i_flush & ~i_rst.
REQ-017 An array read SHALL issue when arr_count > 0 & (ob_count + inflight - deq_fire) < 2, where ob_count is output-buffer occupancy (0..2) and inflight is 1 if a read issued in the previous cycle.
REQ-018 An entry written in cycle t SHALL be eligible for read no earlier than cycle t+1, because arr_count counts it only from t+1.
REQ-019 Read data SHALL be captured into the 2-entry output buffer at the end of the cycle after issue, then appear on o_deq_data in the following cycle.
REQ-020 Latency into an empty block SHALL be: enqueue in cycle t gives o_deq_valid=1 in cycle t+3.
REQ-021 Sustained throughput SHALL be 1 entry/cycle when both sides are continuously ready and the block is non-empty.
REQ-022 The output buffer SHALL be FIFO-ordered; o_deq_data SHALL be stable while o_deq_valid & ~i_deq_ready.
REQ-023 Simultaneous enqueue and read issue SHALL both take effect; arr_count changes by +1 from enqueue and -1 from read issue in that cycle.
REQ-024 At arr_count == DEPTH, o_enq_ready SHALL be 0; dequeue while full SHALL raise o_enq_ready only after a read issue decrements arr_count.
REQ-025 o_count SHALL equal arr_count + inflight + ob_count and SHALL never exceed DEPTH+2.
REQ-026 Flush with i_flush=1 SHALL clear pointers, arr_count, inflight and ob_count at the edge and suppress that cycle's fires; read data in flight SHALL be discarded; array contents are not cleared.

Reset
REQ-027 On i_rst=1 at a clock edge: pointers=0, arr_count=0, inflight=0, ob_count=0.
REQ-028 In the cycle after reset: o_deq_valid=0, o_enq_ready=1, o_count=0; o_deq_data SHALL be 0 after reset.
REQ-029 Reset asserted mid-operation SHALL behave as a flush; it SHALL take priority over i_flush and all handshakes.

Structure
REQ-030 No shared-package typedefs SHALL be used; derived widths are local constants computed from WIDTH and DEPTH.
REQ-031 The array SHALL be one instance of sram_1w1r, with its write port driven by enqueue fire and its read enable driven by REQ-017 issue; the output buffer and control SHALL live in this module.

Verification
REQ-032 Reset, then enqueue 0xA5 in cycle 0 with i_deq_ready=1 -> o_deq_valid=1 with 0xA5 in cycle 3, and o_count reaches 0 after the dequeue.
REQ-033 DEPTH=8, i_deq_ready=0, enqueue 0..11 continuously -> exactly 10 accepted, o_count=10, o_enq_ready=0; then drain -> outputs 0..9 in order.
REQ-034 Both sides always ready, 100 sequential values -> after fill, one dequeue per cycle with no bubbles; values in order.
REQ-035 Random valid/ready at 50% with wrap past 3xDEPTH -> scoreboard matches and o_count equals the model every cycle.
REQ-036 Flush in the cycle after a read issue with o_count=5 -> next cycle o_count=0 and o_deq_valid=0; a subsequent enqueue of 0x3C appears alone after 3 cycles.
REQ-037 i_rst pulse during simultaneous enqueue and dequeue -> neither fire takes effect and all outputs match REQ-028.

Source files
------------

// File: rtl/sram_fifo_pkg.sv
// Shared helpers for the SRAM-backed FIFO: read-issue admission rule for the
// two-entry output buffer.
package sram_fifo_pkg;

  // A new array read may issue only if the buffer, counting the read already
  // in flight and this cycle's pop, still has a free slot when the data lands.
  function automatic logic issue_room(input logic [1:0] ob_count,
                                      input logic       inflight,
                                      input logic       deq_fire);
    return ({1'b0, ob_count} + {2'b00, inflight}) < (3'd2 + {2'b00, deq_fire});
  endfunction

endpackage

// File: rtl/sram_fifo_sram.sv
// Simple dual-port storage array: one write port, one registered read port.
// A same-address read and write in one cycle returns the old contents.
module sram_1w1r #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sram_fifo.sv
// FIFO built on a 1-cycle-latency SRAM with a two-entry output buffer so the
// consumer sees registered data and full throughput despite the read latency.
module sram_fifo
  import sram_fifo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_flush,
  input  logic                      i_enq_valid,
  input  logic [WIDTH-1:0]          i_enq_data,
  output logic                      o_enq_ready,
  output logic                      o_deq_valid,
  output logic [WIDTH-1:0]          o_deq_data,
  input  logic                      i_deq_ready,
  output logic [$clog2(DEPTH+2):0]  o_count
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int ACNT_W = PTR_W + 1;
  localparam int CNT_W  = $clog2(DEPTH + 2) + 1;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and held data stays stable.
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [ACNT_W-1:0] arr_count;
  logic              inflight;
  logic [1:0]        ob_count, ob_count_n, cnt_after;
  logic [WIDTH-1:0]  ob_head, ob_tail, head_n, tail_n;
  logic [WIDTH-1:0]  rd_data;
  logic              enq_fire, deq_fire, rd_issue;

  assign o_enq_ready = (arr_count < ACNT_W'(DEPTH)) & ~i_flush & ~i_rst;
  assign o_deq_valid = (ob_count != 2'd0);
  assign o_deq_data  = ob_head;
  assign enq_fire    = i_enq_valid & o_enq_ready;
  assign deq_fire    = o_deq_valid & i_deq_ready;
  assign rd_issue    = (arr_count != '0) & issue_room(ob_count, inflight, deq_fire)
                       & ~i_flush & ~i_rst;
  assign o_count     = CNT_W'(arr_count) + CNT_W'(inflight) + CNT_W'(ob_count);

  sram_1w1r #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_sram (
    .clk   (i_clk),
    .we    (enq_fire),
    .waddr (wr_ptr),
    .wdata (i_enq_data),
    .re    (rd_issue),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  // Pop first, then land the returning read in the first free slot.
  always_comb begin
    head_n    = ob_head;
    tail_n    = ob_tail;
    cnt_after = ob_count - {1'b0, deq_fire};
    if (deq_fire) head_n = ob_tail;
    if (inflight) begin
      if (cnt_after == 2'd0) head_n = rd_data;
      else                   tail_n = rd_data;
    end
    ob_count_n = cnt_after + {1'b0, inflight};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      arr_count <= '0;
      inflight  <= 1'b0;
      ob_count  <= 2'd0;
      ob_head   <= '0;
      ob_tail   <= '0;
    end else if (i_flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      arr_count <= '0;
      inflight  <= 1'b0;
      ob_count  <= 2'd0;
    end else begin
      if (enq_fire) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_issue) rd_ptr <= rd_ptr + PTR_W'(1);
      arr_count <= arr_count + ACNT_W'(enq_fire) - ACNT_W'(rd_issue);
      inflight  <= rd_issue;
      ob_count  <= ob_count_n;
      ob_head   <= head_n;
      ob_tail   <= tail_n;
    end
  end

endmodule
